// File: rtl/mdu.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy model.
// The product or quotient is computed in one step when the op starts and is
// parked in HI_n/LO_n. A down-counter then holds busy for 5 (mult class) or
// 10 (div class) cycles before the parked result is copied into HI/LO.
// Optional feature: define MDU_MADD_EN to enable madd/maddu/msub/msubu
// (ops 9-12). Without it those ops act like op 0.
module mdu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  MDUOp_E,
  input  logic [31:0] A_E,
  input  logic [31:0] B_E,
  output logic        MDU_start,
  output logic        MDU_busy,
  output logic [31:0] MDUOut_E,
  output logic [31:0] HI_o,
  output logic [31:0] LO_o
);
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nx;
  logic [3:0]  cnt, cnt_nx;
  logic [31:0] hi, lo, hi_n, lo_n;
  logic [31:0] hi_nx, lo_nx, hi_n_nx, lo_n_nx;

  logic        is_mul, is_div;
  logic [63:0] a_sx, b_sx, a_zx, b_zx;
  logic [63:0] prod_s, prod_u, acc, res;
  logic [31:0] q_s, r_s;

  // Decode which ops take the multi-cycle path
  always_comb begin
    is_mul = (MDUOp_E == 4'd1) || (MDUOp_E == 4'd2);
`ifdef MDU_MADD_EN
    is_mul = is_mul || (MDUOp_E >= 4'd9 && MDUOp_E <= 4'd12);
`endif
    is_div = (MDUOp_E == 4'd3) || (MDUOp_E == 4'd4);
  end

  assign MDU_start = (is_mul || is_div) && (state == IDLE);
  assign MDU_busy  = (state == BUSY);
  assign HI_o      = hi;
  assign LO_o      = lo;
  assign MDUOut_E  = (MDUOp_E == 4'd5) ? hi :
                     (MDUOp_E == 4'd6) ? lo : 32'd0;

  // Full-width operands so both products are exact 64-bit results
  assign a_sx   = {{32{A_E[31]}}, A_E};
  assign b_sx   = {{32{B_E[31]}}, B_E};
  assign a_zx   = {32'd0, A_E};
  assign b_zx   = {32'd0, B_E};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;
  assign acc    = {hi, lo};

  // Signed divide; the one overflowing case is pinned rather than left to
  // whatever the divider would produce for it
  always_comb begin
    q_s = 32'd0;
    r_s = 32'd0;
    if (B_E != 32'd0) begin
      if (A_E == 32'h8000_0000 && B_E == 32'hFFFF_FFFF) begin
        q_s = 32'h8000_0000;
        r_s = 32'd0;
      end else begin
        q_s = $signed(A_E) / $signed(B_E);
        r_s = $signed(A_E) % $signed(B_E);
      end
    end
  end

  // Result to park in the shadow registers; divide by zero parks the
  // current HI/LO so the commit leaves them untouched
  always_comb begin
    res = acc;
    case (MDUOp_E)
      4'd1:    res = prod_s;
      4'd2:    res = prod_u;
      4'd3:    res = (B_E == 32'd0) ? acc : {r_s, q_s};
      4'd4:    res = (B_E == 32'd0) ? acc : {A_E % B_E, A_E / B_E};
`ifdef MDU_MADD_EN
      4'd9:    res = acc + prod_s;
      4'd10:   res = acc + prod_u;
      4'd11:   res = acc - prod_s;
      4'd12:   res = acc - prod_u;
`endif
      default: res = acc;
    endcase
  end

  // Next-state: start, count down, commit; moves to HI/LO only when idle
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    hi_nx    = hi;
    lo_nx    = lo;
    hi_n_nx  = hi_n;
    lo_n_nx  = lo_n;
    case (state)
      IDLE: begin
        if (MDU_start) begin
          hi_n_nx  = res[63:32];
          lo_n_nx  = res[31:0];
          cnt_nx   = is_div ? 4'd10 : 4'd5;
          state_nx = BUSY;
        end else if (MDUOp_E == 4'd7) begin
          hi_nx = A_E;
        end else if (MDUOp_E == 4'd8) begin
          lo_nx = A_E;
        end
      end
      BUSY: begin
        cnt_nx = cnt - 4'd1;
        if (cnt == 4'd1) begin
          hi_nx    = hi_n;
          lo_nx    = lo_n;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // State registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      hi_n  <= 32'd0;
      lo_n  <= 32'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
      hi_n  <= hi_n_nx;
      lo_n  <= lo_n_nx;
    end
  end
endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed cases plus random ops compared
// against an arithmetic model of HI/LO.
module tb_mdu;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  MDUOp_E;
  logic [31:0] A_E, B_E;
  logic        MDU_start, MDU_busy;
  logic [31:0] MDUOut_E, HI_o, LO_o;

  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu dut (
    .clk(clk), .rst_n(rst_n), .MDUOp_E(MDUOp_E), .A_E(A_E), .B_E(B_E),
    .MDU_start(MDU_start), .MDU_busy(MDU_busy), .MDUOut_E(MDUOut_E),
    .HI_o(HI_o), .LO_o(LO_o)
  );

  always #5 clk = ~clk;

`ifdef MDU_MADD_EN
  localparam bit MADD = 1'b1;
`else
  localparam bit MADD = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit is_multi(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd4) || (MADD && op >= 4'd9 && op <= 4'd12);
  endfunction

  // Architectural result for {HI,LO} after op completes
  function automatic logic [63:0] ref_res(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] hl);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub;
    logic [63:0] ps, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    ps = 64'(sa * sb);
    pu = 64'(ua * ub);
    case (op)
      4'd1: return ps;
      4'd2: return pu;
      4'd3: begin
        if (b == 32'd0) return hl;
        sq = sa / sb;
        sr = sa % sb;
        return {sr[31:0], sq[31:0]};
      end
      4'd4: begin
        if (b == 32'd0) return hl;
        return {32'(ua % ub), 32'(ua / ub)};
      end
      4'd7: return {a, hl[31:0]};
      4'd8: return {hl[63:32], a};
      4'd9:  return MADD ? hl + ps : hl;
      4'd10: return MADD ? hl + pu : hl;
      4'd11: return MADD ? hl - ps : hl;
      4'd12: return MADD ? hl - pu : hl;
      default: return hl;
    endcase
  endfunction

  // Issue one op in idle, follow it to completion, compare against the model
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int n;
    int lat;
    lat = (op == 4'd3 || op == 4'd4) ? 10 : 5;
    @(negedge clk);
    MDUOp_E = op; A_E = a; B_E = b;
    #1;
    check($sformatf("start op%0d", op), MDU_start, is_multi(op));
    if (op == 4'd5)      check("mfhi", MDUOut_E, m_hi);
    else if (op == 4'd6) check("mflo", MDUOut_E, m_lo);
    else                 check("out_zero", MDUOut_E, 0);
    exp = ref_res(op, a, b, {m_hi, m_lo});
    @(posedge clk); #1;
    MDUOp_E = 4'd0;
    if (is_multi(op)) begin
      n = 0;
      while (MDU_busy && n < 20) begin
        n++;
        @(posedge clk); #1;
      end
      check($sformatf("busy_len op%0d", op), n, lat);
      MDUOp_E = 4'd5; #1;
      check("mfhi_after", MDUOut_E, exp[63:32]);
      MDUOp_E = 4'd0;
    end else begin
      check("no_busy", MDU_busy, 0);
    end
    {m_hi, m_lo} = exp;
    check($sformatf("hilo op%0d a=%h b=%h", op, a, b), {HI_o, LO_o}, {m_hi, m_lo});
  endtask

  initial begin
    logic [3:0] ops [14];
    logic [63:0] exp;
    logic [3:0] op;
    logic [31:0] a, b;
    int n;
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
            4'd9, 4'd10, 4'd11, 4'd12, 4'd14};

    // Reset state
    rst_n = 1'b0; MDUOp_E = 4'd0; A_E = 32'd0; B_E = 32'd0;
    #2;
    check("rst_busy", MDU_busy, 0);
    check("rst_hilo", {HI_o, LO_o}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    run(4'd1, 32'hFFFF_FFFE, 32'd3);
    check("mult_ex", {HI_o, LO_o}, 64'hFFFF_FFFF_FFFF_FFFA);
    run(4'd2, 32'hFFFF_FFFE, 32'd3);
    check("multu_ex", {HI_o, LO_o}, 64'h0000_0002_FFFF_FFFA);
    run(4'd3, 32'hFFFF_FFF9, 32'd2);
    check("div_ex", {HI_o, LO_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    run(4'd4, 32'd7, 32'd0);
    check("divu_zero", {HI_o, LO_o}, 64'hFFFF_FFFF_FFFF_FFFD);
    run(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_ovf", {HI_o, LO_o}, 64'h0000_0000_8000_0000);
    run(4'd8, 32'h1234_5678, 32'd0);
    run(4'd6, 32'd0, 32'd0);
    check("mtlo_mflo", LO_o, 32'h1234_5678);

    // mthi on the third busy cycle of a mult is ignored
    @(negedge clk);
    MDUOp_E = 4'd1; A_E = 32'd1000; B_E = 32'hFFFF_FFFF;
    exp = ref_res(4'd1, A_E, B_E, {m_hi, m_lo});
    @(posedge clk); #1;
    MDUOp_E = 4'd0;
    repeat (2) begin @(posedge clk); #1; end
    MDUOp_E = 4'd7; A_E = 32'hDEAD_BEEF; #1;
    check("busy_nostart", MDU_start, 0);
    @(posedge clk); #1;
    MDUOp_E = 4'd0;
    n = 0;
    while (MDU_busy && n < 20) begin n++; @(posedge clk); #1; end
    check("busy_drop", MDU_busy, 0);
    {m_hi, m_lo} = exp;
    check("mthi_ignored", {HI_o, LO_o}, exp);

    // Reset on busy cycle 4 of a divide abandons it
    @(negedge clk);
    MDUOp_E = 4'd3; A_E = 32'd100; B_E = 32'd7;
    @(posedge clk); #1;
    MDUOp_E = 4'd0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_busy", MDU_busy, 1);
    rst_n = 1'b0; #1;
    check("mid_rst_busy", MDU_busy, 0);
    check("mid_rst_hilo", {HI_o, LO_o}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (12) @(posedge clk);
    #1;
    check("no_commit", {HI_o, LO_o}, 64'd0);
    check("no_commit_busy", MDU_busy, 0);

    // madd example; without the feature it must be a no-op
    run(4'd7, 32'd0, 32'd0);
    run(4'd8, 32'hFFFF_FFFF, 32'd0);
    run(4'd9, 32'd1, 32'd1);
    check("madd_ex", {HI_o, LO_o}, MADD ? 64'h0000_0001_0000_0000 : 64'h0000_0000_FFFF_FFFF);

    // Random ops against the model
    for (int i = 0; i < 80; i++) begin
      op = ops[$urandom_range(0, 13)];
      a = $urandom();
      b = $urandom();
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'($urandom_range(1, 9));
        2: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        default: ;
      endcase
      run(op, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001: clk  input  1  single clock; all state updates on rising edge.
REQ-002: rst_n  input  1  asynchronous, active-low reset.
REQ-003: MDUOp_E  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo, 9 madd, 10 maddu, 11 msub, 12 msubu; 13-15 none.
REQ-004: A_E  input  32  rs operand.
REQ-005: B_E  input  32  rt operand.
REQ-006: MDU_start  output  1  combinational; high when MDUOp_E is a multi-cycle op (1-4, or 9-12 per REQ-024) and MDU_busy is low.
REQ-007: MDU_busy  output  1  registered; high while a multi-cycle op is in progress.
REQ-008: MDUOut_E  output  32  combinational; HI for mfhi, LO for mflo, 0 otherwise.
REQ-009: HI_o, LO_o  output  32 each  current HI/LO register values.

Function
REQ-010: The block SHALL hold state IDLE or BUSY plus a 4-bit down-counter, HI, LO, and result shadow registers HI_n, LO_n.
REQ-011: IDLE with MDU_start high: at the edge, capture the result into HI_n/LO_n, load the counter with 5 for mult-class ops (1, 2, 9-12) or 10 for div-class ops (3, 4), and go to BUSY.
REQ-012: In BUSY, the counter SHALL decrement each cycle; on the edge where it goes from 1 to 0, copy HI_n/LO_n into HI/LO, go to IDLE, and drop MDU_busy. Busy is therefore high for exactly 5 or 10 cycles after the start edge.
REQ-013: mult/multu: {HI,LO} = 64-bit signed/unsigned product of A_E and B_E.
REQ-014: div/divu: LO = quotient, HI = remainder, signed (truncate toward zero, remainder takes the sign of the dividend) or unsigned.
REQ-015: Divide by zero (B_E == 0): busy still runs 10 cycles; HI/LO SHALL remain unchanged.
REQ-016: Signed overflow 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
REQ-017: mthi/mtlo in IDLE: HI or LO = A_E at the edge, single cycle, no busy.
REQ-018: Any MDUOp_E nonzero while BUSY SHALL be ignored. The hazard logic stalls these ops; the MDU does not queue them.
REQ-019: mfhi/mflo in IDLE return the committed HI/LO. In the cycle after the final busy cycle, MDUOut_E SHALL already show the new value.
REQ-020: Arithmetic SHALL be computed combinationally at start and held in the shadow registers. The cycle count is an architectural latency model, not an iterative datapath.

Reset
REQ-021: rst_n low SHALL immediately force IDLE, counter = 0, MDU_busy = 0, HI = LO = HI_n = LO_n = 0, independent of clk.
REQ-022: Reset asserted mid-operation SHALL abandon the operation; no commit occurs after release.
REQ-023: After release, the first rising edge SHALL process MDUOp_E normally.

Configuration
REQ-024: Macro MDU_MADD_EN. When defined, ops 9-12 set {HI,LO} = {HI,LO} ± the signed (9, 11) or unsigned (10, 12) product of A_E and B_E, modulo 2^64, with mult latency. {HI,LO} is sampled at start. When undefined, ops 9-12 are treated as op 0: MDU_start stays low and state is unchanged.

Verification
REQ-025: mult A=0xFFFFFFFE, B=3 -> start high 1 cycle, busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. multu on the same operands -> HI=0x2, LO=0xFFFFFFFA.
REQ-026: div A=0xFFFFFFF9 (-7), B=2 -> busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu A=7, B=0 -> busy 10 cycles, HI/LO unchanged.
REQ-027: mtlo A=0x12345678, then mflo next cycle -> MDUOut_E=0x12345678, busy never set.
REQ-028: mult started, then mthi A=0xDEADBEEF presented on the 3rd busy cycle -> ignored; HI equals the mult result after busy drops.
REQ-029: Start div, pull rst_n low on busy cycle 4 -> busy=0 and HI=LO=0 immediately; no later commit.
REQ-030: With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, madd A=1, B=1 -> HI=1, LO=0 after 5 cycles. Without it: the same stimulus -> start low, HI/LO unchanged.
